// File: rtl/random_pkg.sv
// Shared definitions for the LFSR bank: feedback masks, lane salt and FSM states.
package random_pkg;

  localparam logic [31:0] SALT = 32'h9E37_79B9;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_state_t;

  // Right-shift Galois taps giving a maximal-length sequence for each legal width.
  function automatic logic [31:0] lfsr_mask(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'hA300_0000;
    endcase
  endfunction

  // Per-lane power-up state so lanes never start in lockstep; zero would lock a lane up.
  function automatic logic [31:0] lane_reset_value(input int unsigned width,
                                                   input logic [31:0] seed,
                                                   input int unsigned chan);
    logic [31:0] keep;
    logic [31:0] value;
    keep  = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    value = (seed ^ (chan * SALT)) & keep;
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/random_lfsr_lane.sv
// One Galois LFSR lane: state register, single-step update and seed load.
module random_lfsr_lane
  import random_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_state
);

  localparam logic [31:0]      MASK32 = lfsr_mask(WIDTH);
  localparam logic [WIDTH-1:0] MASK   = MASK32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state;

  assign next_state = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? MASK : '0);

  // NOTE: state registers use non-blocking assignments so every lane samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RESET_VALUE;
    end else if (load) begin
      state <= (load_data == '0) ? ONE : load_data;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/random_lfsr_bank.sv
// Bank of independent LFSR lanes emitting one multi-lane word every STEPS enabled cycles.
module random_lfsr_bank
  import random_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               CHANNELS = 4,
  parameter int               STEPS    = 1,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(16'hACE1),
  localparam int              CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      seed_valid,
  input  logic [CHAN_W-1:0]         seed_chan,
  input  logic [WIDTH-1:0]          seed_data,
  output logic                      seed_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
);

  localparam int              CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  fsm_state_t                state;
  logic [CNT_W-1:0]          count;
  logic [CHANNELS*WIDTH-1:0] lane_next;
  logic                      step_en;
  logic                      seed_hit;
  logic                      xfer;

  assign seed_ready = (state == HOLD);
  assign step_en    = (state == FILL) && enable;
  // Out-of-range channels still complete the handshake but touch nothing.
  assign seed_hit   = seed_valid && (state == HOLD) && (int'(seed_chan) < CHANNELS);
  assign xfer       = out_valid && out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [31:0] RV32 = lane_reset_value(WIDTH, 32'(SEED), c);
    random_lfsr_lane #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RV32[WIDTH-1:0])
    ) u_lane (
      .clock     (clock),
      .resetn    (resetn),
      .step      (step_en),
      .load      (seed_hit && (int'(seed_chan) == c)),
      .load_data (seed_data),
      .next_state(lane_next[c*WIDTH +: WIDTH])
    );
  end

  // NOTE: out_data is a plain register bank, so it is reset along with the control state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= FILL;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (enable) begin
            if (count == LAST) begin
              out_data  <= lane_next;
              out_valid <= 1'b1;
              count     <= '0;
              state     <= HOLD;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (xfer || seed_hit) begin
            out_valid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_random_lfsr_bank.sv
// Randomized and directed checks of random_lfsr_bank against a behavioural lane model.
module tb_random_lfsr_bank;

  localparam int AC = 5;  // dut_a: WIDTH 16, 5 lanes, STEPS 1
  localparam int BC = 4;  // dut_b: WIDTH 16, 4 lanes, STEPS 4
  localparam int BS = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        a_en = 0, a_sv = 0, a_or = 0, a_sr, a_ov;
  logic [2:0]  a_chan = '0;
  logic [15:0] a_sd = '0;
  logic [79:0] a_od;

  logic        b_en = 0, b_sv = 0, b_or = 0, b_sr, b_ov;
  logic [1:0]  b_chan = '0;
  logic [15:0] b_sd = '0;
  logic [63:0] b_od;

  logic        c_en = 0, c_sv = 0, c_or = 0, c_sr, c_ov;
  logic [0:0]  c_chan = '0;
  logic [7:0]  c_sd = '0;
  logic [7:0]  c_od;

  random_lfsr_bank #(.WIDTH(16), .CHANNELS(AC), .STEPS(1)) dut_a (
    .clock(clock), .resetn(resetn), .enable(a_en), .seed_valid(a_sv), .seed_chan(a_chan),
    .seed_data(a_sd), .seed_ready(a_sr), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od));

  random_lfsr_bank #(.WIDTH(16), .CHANNELS(BC), .STEPS(BS)) dut_b (
    .clock(clock), .resetn(resetn), .enable(b_en), .seed_valid(b_sv), .seed_chan(b_chan),
    .seed_data(b_sd), .seed_ready(b_sr), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od));

  random_lfsr_bank #(.WIDTH(8), .CHANNELS(1), .STEPS(1)) dut_c (
    .clock(clock), .resetn(resetn), .enable(c_en), .seed_valid(c_sv), .seed_chan(c_chan),
    .seed_data(c_sd), .seed_ready(c_sr), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned galois(input longint unsigned s, input int w);
    longint unsigned mask;
    mask = (w == 8) ? 64'hB8 : (w == 16) ? 64'hB400 : 64'hA300_0000;
    return (s % 2 == 1) ? ((s / 2) ^ mask) : (s / 2);
  endfunction

  function automatic longint unsigned reset_lane(input int w, input longint unsigned seed, input int c);
    longint unsigned v;
    v = (seed ^ (longint'(c) * 64'h9E37_79B9)) % (64'd1 << w);
    return (v == 0) ? 1 : v;
  endfunction

  // Behavioural model of dut_a: lanes, the word on display, and whether a word is waiting.
  longint unsigned ma_lane[AC];
  longint unsigned ma_word[AC];
  bit              ma_valid;
  bit              ma_hold;
  int              ma_need;

  function automatic void ma_reset();
    for (int c = 0; c < AC; c++) begin
      ma_lane[c] = reset_lane(16, 64'hACE1, c);
      ma_word[c] = 0;
    end
    ma_valid = 0;
    ma_hold  = 0;
    ma_need  = 1;
  endfunction

  function automatic logic [79:0] ma_pack();
    logic [79:0] p;
    p = '0;
    for (int c = 0; c < AC; c++) p[c*16 +: 16] = ma_word[c][15:0];
    return p;
  endfunction

  function automatic void ma_edge();
    bit leave;
    leave = 0;
    if (!ma_hold) begin
      if (a_en) begin
        for (int c = 0; c < AC; c++) ma_lane[c] = galois(ma_lane[c], 16);
        ma_need--;
        if (ma_need == 0) begin
          for (int c = 0; c < AC; c++) ma_word[c] = ma_lane[c];
          ma_valid = 1;
          ma_hold  = 1;
        end
      end
    end else begin
      if (a_sv && int'(a_chan) < AC) begin
        ma_lane[a_chan] = (a_sd == 0) ? 1 : a_sd;
        leave = 1;
      end
      if (a_or) leave = 1;
      if (leave) begin
        ma_valid = 0;
        ma_hold  = 0;
        ma_need  = 1;
      end
    end
  endfunction

  task automatic a_cycle();
    ma_edge();
    @(posedge clock);
    #1;
    check("a_valid", a_ov, ma_valid);
    check("a_data", a_od, ma_pack());
    check("a_seed_ready", a_sr, ma_hold);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #2;
    check("rst_a_valid", a_ov, 0);
    check("rst_a_data", a_od, 0);
    check("rst_a_sready", a_sr, 0);
    check("rst_b_valid", b_ov, 0);
    check("rst_b_data", b_od, 0);
    check("rst_c_valid", c_ov, 0);
    check("rst_c_data", c_od, 0);
    @(negedge clock);
    resetn = 1'b1;
    ma_reset();
  endtask

  task automatic t1_sequence();
    a_en = 1; a_or = 1; a_sv = 0;
    a_cycle();
    check("t1_word1", a_od[15:0], 16'hE270);
    check("t1_valid1", a_ov, 1);
    a_cycle();
    a_cycle();
    check("t1_word2", a_od[15:0], 16'h7138);
  endtask

  function automatic logic [63:0] b_expect();
    logic [63:0]     p;
    longint unsigned s;
    p = '0;
    for (int c = 0; c < BC; c++) begin
      s = reset_lane(16, 64'hACE1, c);
      for (int k = 0; k < BS; k++) s = galois(s, 16);
      p[c*16 +: 16] = s[15:0];
    end
    return p;
  endfunction

  initial begin
    logic [79:0]     held;
    logic [15:0]     x;
    int              highs;
    int              pat[7];
    bit              seen[256];
    logic [7:0]      words[$];
    longint unsigned cs;

    // Test 1: lane-0 sequence after reset.
    do_reset();
    t1_sequence();

    // Test 3: seeding lane 2 with zero restarts it from 1.
    a_or = 0;
    a_cycle();
    a_sv = 1; a_chan = 3'd2; a_sd = 16'h0000;
    a_cycle();
    a_sv = 0;
    a_cycle();
    check("t3_lane2", a_od[47:32], 16'hB400);

    // Test 4: seed and output transfer together, then an out-of-range seed channel.
    x = 16'($urandom_range(1, 65535));
    a_sv = 1; a_chan = 3'd1; a_sd = x; a_or = 1;
    a_cycle();
    a_sv = 0; a_or = 0;
    a_cycle();
    cs = galois(longint'(x), 16);
    check("t4_lane1", a_od[31:16], cs[15:0]);
    held = a_od;
    a_sv = 1; a_chan = 3'd7; a_sd = 16'($urandom);
    a_cycle();
    a_sv = 0;
    check("t4_chan7_data", a_od, held);
    check("t4_chan7_valid", a_ov, 1);

    // Randomized traffic on dut_a.
    for (int i = 0; i < 400; i++) begin
      a_en   = ($urandom % 4) != 0;
      a_or   = ($urandom % 3) != 0;
      a_sv   = ($urandom % 4) == 0;
      a_chan = 3'($urandom % 8);
      a_sd   = (($urandom % 5) == 0) ? 16'h0000 : 16'($urandom);
      a_cycle();
    end
    a_sv = 0;

    // Test 6: asynchronous reset in the middle of FILL.
    a_en = 1; a_or = 1;
    for (int i = 0; i < 4 && ma_hold; i++) a_cycle();
    if (ma_hold) a_cycle();
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_valid", a_ov, 0);
    check("t6_async_data", a_od, 0);
    check("t6_async_sready", a_sr, 0);
    @(negedge clock);
    resetn = 1'b1;
    ma_reset();
    t1_sequence();

    // Test 2: STEPS=4, consumer stalled.
    b_en = 1; b_or = 0;
    do_reset();
    for (int k = 1; k <= BS; k++) begin
      @(posedge clock); #1;
      check("t2_valid_rise", b_ov, k == BS);
    end
    check("t2_word", b_od, b_expect());
    for (int i = 0; i < 20; i++) begin
      b_en = 1'($urandom);
      @(posedge clock); #1;
      check("t2_hold_valid", b_ov, 1);
      check("t2_hold_data", b_od, b_expect());
      check("t2_hold_sready", b_sr, 1);
    end
    // Reset in HOLD discards the pending word at once.
    #2;
    resetn = 1'b0;
    #1;
    check("t2_hold_rst_valid", b_ov, 0);
    check("t2_hold_rst_data", b_od, 0);
    @(negedge clock);
    resetn = 1'b1;
    ma_reset();
    pat = '{1, 0, 1, 0, 0, 1, 1};
    highs = 0;
    for (int i = 0; i < 7; i++) begin
      b_en = 1'(pat[i]);
      @(posedge clock); #1;
      highs += pat[i];
      check("t2_gap_valid", b_ov, highs >= BS);
    end
    check("t2_gap_word", b_od, b_expect());

    // Test 5: WIDTH=8 free run.
    c_en = 1; c_or = 1;
    do_reset();
    cs = reset_lane(8, 64'hE1, 0);
    for (int i = 0; i < 1200 && words.size() < 256; i++) begin
      @(posedge clock); #1;
      if (c_ov) begin
        cs = galois(cs, 8);
        check("t5_model", c_od, cs[7:0]);
        words.push_back(c_od);
      end
    end
    check("t5_word_count", words.size(), 256);
    if (words.size() == 256) begin
      for (int i = 0; i < 255; i++) begin
        check("t5_nonzero", words[i] != 0, 1);
        check("t5_distinct", seen[words[i]], 0);
        seen[words[i]] = 1;
      end
      check("t5_wrap", words[255], words[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
